// File: rtl/branch_pred_ctrl_pkg.sv
// branch_pred_ctrl_pkg: shared type codes, BHT encodings, FSM states and counter helper
package branch_pred_ctrl_pkg;
  localparam logic [1:0] PT_JZE = 2'b01;
  localparam logic [1:0] PT_JNE = 2'b10;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [6:0] OP_JZE = 7'b1000001;
  localparam logic [6:0] OP_JNE = 7'b1010000;
  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic up);
    return up ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_pred_ctrl_queue.sv
// pred_queue: in-order FIFO of in-flight predictions with push/pop/clear
module pred_queue #(
  parameter int W = 7,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  // storage carries no reset; only pointers define validity
  always_ff @(posedge clk)
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  // pointers and occupancy; clear drops everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rd_q    <= wr_q;
      count_q <= '0;
    end else begin
      rd_q    <= rd_q + AW'(pop_i);
      wr_q    <= wr_q + AW'(push_i);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit BHT predictor with in-flight queue and mispredict flush; BRANCH_PRED_STATS_EN adds pop/miss counters
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int IDX_W = 4,
  parameter int QDEPTH = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid_i,
  input  logic            fetch_branch_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  input  logic [1:0]      fetch_type_i,
  output logic            pred_taken_o,
  output logic            stall_o,
  input  logic            exe_checked_i,
  input  logic            exe_incorrect_i,
  input  logic            exe_correct_i,
  output logic            chk_last_pred_o,
  output logic [1:0]      chk_pred_type_o,
  output logic            flush_o,
  output logic            redirect_taken_o,
  output logic            err_underflow_o
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [15:0]     stat_total_o,
  output logic [15:0]     stat_miss_o
`endif
);
  localparam int EW = IDX_W + 3;
  localparam int NB = 2 ** IDX_W;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int QW = $clog2(QDEPTH) + 1;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic [FW-1:0]    fcnt_q;
  logic             flush_q, redir_q, uf_q;
  logic [1:0]       bht_q [NB];
  logic [IDX_W-1:0] fidx, hidx;
  logic [EW-1:0]    head;
  logic [QW-1:0]    count;
  logic             empty, full, run, pop, mis, push;
  logic             unused_pc;
  assign unused_pc = ^fetch_pc_i;
  assign fidx = fetch_pc_i[IDX_W-1:0];
  assign hidx = head[EW-1:3];
  assign run  = state_q == S_RUN;
  assign pop  = run && exe_checked_i && !empty;
  assign mis  = pop && exe_incorrect_i;
  assign push = run && fetch_valid_i && fetch_branch_i && !full && !mis;
  assign stall_o          = run ? full : 1'b1;
  assign pred_taken_o     = bht_q[fidx][1];
  assign chk_last_pred_o  = empty ? 1'b0 : head[2];
  assign chk_pred_type_o  = empty ? 2'b00 : head[1:0];
  assign flush_o          = flush_q;
  assign redirect_taken_o = redir_q;
  assign err_underflow_o  = uf_q;
  pred_queue #(.W(EW), .DEPTH(QDEPTH)) u_q (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .clear_i(mis),
    .data_i({fidx, pred_taken_o, fetch_type_i}), .head_o(head),
    .count_o(count), .empty_o(empty), .full_o(full)
  );
  // INIT sweeps the table once, FLUSH holds fetch for FLUSH_CYCLES after a mispredict
  always_comb
    state_d = (state_q == S_INIT)  ? ((init_idx_q == '1) ? S_RUN : S_INIT) :
              (state_q == S_FLUSH) ? ((fcnt_q == '0) ? S_RUN : S_FLUSH) :
              mis ? S_FLUSH : S_RUN;
  // control state, flush pulse and sticky underflow flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      fcnt_q     <= '0;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= (state_q == S_INIT) ? init_idx_q + IDX_W'(1) : init_idx_q;
      fcnt_q     <= mis ? FW'(FLUSH_CYCLES - 1) : (state_q == S_FLUSH) ? fcnt_q - FW'(1) : fcnt_q;
      flush_q    <= mis;
      redir_q    <= mis && exe_correct_i;
      uf_q       <= uf_q || (run && exe_checked_i && empty);
    end
  // table written by the init sweep, then trained by each resolved branch
  always_ff @(posedge clk)
    if (state_q == S_INIT) bht_q[init_idx_q] <= WNT;
    else if (pop) bht_q[hidx] <= sat_upd(bht_q[hidx], exe_correct_i);
`ifdef BRANCH_PRED_STATS_EN
  logic [15:0] tot_q, miss_q;
  assign stat_total_o = tot_q;
  assign stat_miss_o  = miss_q;
  // saturating resolve/mispredict counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tot_q  <= '0;
      miss_q <= '0;
    end else begin
      tot_q  <= tot_q + 16'(pop && tot_q != 16'hFFFF);
      miss_q <= miss_q + 16'(mis && miss_q != 16'hFFFF);
    end
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: scoreboard bench with a queue-based behavioural predictor model
module tb_branch_pred_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetch_valid = 0, fetch_branch = 0, exe_checked = 0, exe_incorrect = 0, exe_correct = 0;
  logic [9:0] fetch_pc = '0;
  logic [1:0] fetch_type = '0;
  logic pred_taken, stall, chk_last_pred, flush, redirect_taken, err_underflow;
  logic [1:0] chk_pred_type;
`ifdef BRANCH_PRED_STATS_EN
  logic [15:0] stat_total, stat_miss;
`endif
  typedef struct {int idx; bit pred; logic [1:0] typ;} ent_t;
  ent_t mq[$];
  bit exp_flush[$];
  int bht[16];
  int init_left = 0, flush_left = 0, tot = 0, miss = 0;
  bit uf = 0, mon_r;
  int checks = 0, failures = 0;

  branch_pred_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid), .fetch_branch_i(fetch_branch),
    .fetch_pc_i(fetch_pc), .fetch_type_i(fetch_type), .pred_taken_o(pred_taken), .stall_o(stall),
    .exe_checked_i(exe_checked), .exe_incorrect_i(exe_incorrect), .exe_correct_i(exe_correct),
    .chk_last_pred_o(chk_last_pred), .chk_pred_type_o(chk_pred_type), .flush_o(flush),
    .redirect_taken_o(redirect_taken), .err_underflow_o(err_underflow)
`ifdef BRANCH_PRED_STATS_EN
    , .stat_total_o(stat_total), .stat_miss_o(stat_miss)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && (flush || exp_flush.size() > 0)) begin
      if (exp_flush.size() == 0) chk("flush_unexpected", int'(flush), 0);
      else begin
        mon_r = exp_flush.pop_front();
        chk("flush_pulse", int'(flush), 1);
        chk("redirect_taken", int'(redirect_taken), int'(mon_r));
      end
    end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 0;
    {fetch_valid, fetch_branch, exe_checked, exe_incorrect, exe_correct} = '0;
    mq.delete();
    exp_flush.delete();
    uf = 0; flush_left = 0; tot = 0; miss = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_stall", int'(stall), 1);
      chk("rst_flush", int'(flush), 0);
      chk("rst_err", int'(err_underflow), 0);
      chk("rst_chk_pred", int'(chk_last_pred), 0);
      chk("rst_chk_type", int'(chk_pred_type), 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1;
    init_left = 16;
  endtask

  task automatic cyc(input bit fv, input bit fb, input logic [9:0] pc, input logic [1:0] ft,
                     input bit ec, input bit ei, input bit ecr);
    bit es, p, mis;
    int ix;
    ent_t e;
    @(negedge clk);
    fetch_valid = fv; fetch_branch = fb; fetch_pc = pc; fetch_type = ft;
    exe_checked = ec; exe_incorrect = ei; exe_correct = ecr;
    #1;
    ix = int'(pc[3:0]);
    es = init_left > 0 || flush_left > 0 || mq.size() == 4;
    p = bht[ix] >= 2;
    chk("stall", int'(stall), int'(es));
    if (init_left == 0) chk("pred_taken", int'(pred_taken), int'(p));
    chk("chk_last_pred", int'(chk_last_pred), mq.size() > 0 ? int'(mq[0].pred) : 0);
    chk("chk_pred_type", int'(chk_pred_type), mq.size() > 0 ? int'(mq[0].typ) : 0);
    chk("err_underflow", int'(err_underflow), int'(uf));
`ifdef BRANCH_PRED_STATS_EN
    chk("stat_total", int'(stat_total), tot);
    chk("stat_miss", int'(stat_miss), miss);
`endif
    if (init_left > 0) begin
      bht[16 - init_left] = 1;
      init_left--;
    end else if (flush_left > 0) flush_left--;
    else begin
      mis = 0;
      if (ec && mq.size() == 0) uf = 1;
      else if (ec) begin
        e = mq.pop_front();
        bht[e.idx] = ecr ? (bht[e.idx] == 3 ? 3 : bht[e.idx] + 1) : (bht[e.idx] == 0 ? 0 : bht[e.idx] - 1);
        tot = tot < 65535 ? tot + 1 : tot;
        if (ei) begin
          mis = 1;
          miss = miss < 65535 ? miss + 1 : miss;
          mq.delete();
          exp_flush.push_back(ecr);
          flush_left = 2;
        end
      end
      if (fv && fb && !es && !mis) mq.push_back('{ix, p, ft});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 10'h0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    bit ecr, ei;
    do_reset();
    idle(17);
    for (int i = 0; i < 16; i++) cyc(1, 0, 10'(i * 17), 2'b01, 0, 0, 0);
    // train index 5 up to strongly taken, then saturate
    cyc(1, 1, 10'h005, 2'b01, 0, 0, 0);
    cyc(1, 1, 10'h005, 2'b01, 0, 0, 0);
    cyc(0, 0, 10'h005, 2'b00, 1, 0, 1);
    cyc(0, 0, 10'h005, 2'b00, 1, 0, 1);
    cyc(1, 1, 10'h005, 2'b10, 0, 0, 0);
    cyc(1, 0, 10'h005, 2'b00, 1, 0, 1);
    cyc(1, 0, 10'h005, 2'b00, 0, 0, 0);
    // fill the queue, stall on the fifth, pop+fetch while full
    for (int i = 1; i <= 4; i++) cyc(1, 1, 10'(i), 2'(i), 0, 0, 0);
    cyc(1, 1, 10'h006, 2'b01, 0, 0, 0);
    cyc(1, 1, 10'h007, 2'b01, 1, 0, 0);
    cyc(0, 0, 10'h000, 2'b00, 0, 0, 0);
    repeat (3) cyc(0, 0, 10'h000, 2'b00, 1, 0, 0);
    // mispredict on a JNE predicted not-taken, younger JZE discarded
    cyc(1, 1, 10'h008, 2'b10, 0, 0, 0);
    cyc(1, 1, 10'h009, 2'b01, 0, 0, 0);
    cyc(1, 1, 10'h00A, 2'b01, 1, 1, 1);
    cyc(1, 1, 10'h00B, 2'b01, 1, 1, 0);
    cyc(1, 1, 10'h00B, 2'b01, 1, 0, 0);
    cyc(0, 0, 10'h008, 2'b00, 0, 0, 0);
    // underflow with empty queue, BHT must not move
    cyc(0, 0, 10'h000, 2'b00, 1, 0, 1);
    idle(2);
    for (int i = 0; i < 16; i++) cyc(1, 0, 10'(i), 2'b00, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      ecr = 1'($urandom_range(0, 1));
      ei = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? (mq[0].pred ^ ecr) : 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
          2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, ei, ecr);
    end
    // reset in the middle of the init sweep restarts it
    do_reset();
    idle(7);
    do_reset();
    idle(18);
    for (int i = 0; i < 16; i++) cyc(1, 0, 10'(i), 2'b00, 0, 0, 0);
    if (exp_flush.size() != 0) chk("flush_missing", 0, exp_flush.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
